// File: rtl/gpu_fbuffer_scanout_pkg.sv
// Shared types and constants for the framebuffer scanout block.
package gpu_fbuffer_scanout_pkg;

    localparam int FB_AW_DEF = 13;
    localparam int LCD_W_DEF = 160;
    localparam int LCD_H_DEF = 144;

    typedef enum logic [1:0] {
        SCANOUT_IDLE = 2'd0,
        SCANOUT_RUN  = 2'd1,
        SCANOUT_DONE = 2'd2
    } scanout_state_e;

    // BGP holds four 2-bit shades; colour index c selects bits [2c+1:2c].
    function automatic logic [1:0] pal_map(input logic [7:0] bgp, input logic [1:0] c);
        return bgp[{c, 1'b0} +: 2];
    endfunction

endpackage

// File: rtl/gpu_fb_pixel_shifter.sv
// Two-slot framebuffer word buffer: selects the current pixel out of the head word,
// maps it through the palette, and retires/promotes words as pixels are consumed.
module gpu_fb_pixel_shifter
    import gpu_fbuffer_scanout_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        load,
    input  logic [15:0] data,
    input  logic        accept,
    input  logic [2:0]  fine,
    input  logic [2:0]  x_lo,
    input  logic [7:0]  bgp,
    output logic        cur_valid,
    output logic        nxt_valid,
    output logic [1:0]  shade
);

    logic [15:0] cur_q, cur_d, nxt_q, nxt_d;
    logic        cur_vld_q, cur_vld_d, nxt_vld_q, nxt_vld_d;
    logic [2:0]  pix_idx;
    logic [2:0]  bit_sel;
    logic [1:0]  color;
    logic        retire;

    assign pix_idx = fine + x_lo;
    assign bit_sel = 3'd7 - pix_idx;
    assign retire  = cur_vld_q && accept && (pix_idx == 3'd7);

    // Leftmost pixel lives in bit 7 of each byte; high plane supplies the colour MSB.
    assign color = {cur_q[{1'b1, bit_sel}], cur_q[{1'b0, bit_sel}]};
    assign shade = pal_map(bgp, color);

    assign cur_valid = cur_vld_q;
    assign nxt_valid = nxt_vld_q;

    always_comb begin
        cur_d     = cur_q;
        nxt_d     = nxt_q;
        cur_vld_d = cur_vld_q;
        nxt_vld_d = nxt_vld_q;
        if (retire) begin
            cur_d     = nxt_q;
            cur_vld_d = nxt_vld_q;
            nxt_vld_d = 1'b0;
        end
        // Returning data fills whichever slot is free after this cycle's retire.
        if (load) begin
            if (!cur_vld_d) begin
                cur_d     = data;
                cur_vld_d = 1'b1;
            end else begin
                nxt_d     = data;
                nxt_vld_d = 1'b1;
            end
        end
        if (clear) begin
            cur_vld_d = 1'b0;
            nxt_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_q     <= '0;
            nxt_q     <= '0;
            cur_vld_q <= 1'b0;
            nxt_vld_q <= 1'b0;
        end else begin
            cur_q     <= cur_d;
            nxt_q     <= nxt_d;
            cur_vld_q <= cur_vld_d;
            nxt_vld_q <= nxt_vld_d;
        end
    end

endmodule

// File: rtl/gpu_fbuffer_scanout.sv
// Framebuffer scanout: crops a scrolled 160x144 window out of the 256x256 2bpp background
// and streams palette-mapped shades to the LCD over a valid/ready interface.
//   state        | meaning
//   SCANOUT_IDLE | waiting for iEnable; scroll and palette captured on start
//   SCANOUT_RUN  | fetching words and streaming pixels
//   SCANOUT_DONE | one-cycle oFrameDone pulse
module gpu_fbuffer_scanout
    import gpu_fbuffer_scanout_pkg::*;
#(
    parameter int FB_AW = FB_AW_DEF,
    parameter int LCD_W = LCD_W_DEF,
    parameter int LCD_H = LCD_H_DEF
) (
    input  logic             iClock,
    input  logic             iReset_n,
    input  logic             iEnable,
    input  logic [7:0]       iScx,
    input  logic [7:0]       iScy,
    input  logic [7:0]       iBgp,
    output logic [FB_AW-1:0] oFbAddr,
    output logic             oFbRe,
    input  logic [15:0]      iFbData,
    output logic [1:0]       oPixel,
    output logic             oValid,
    input  logic             iReady,
    output logic             oLineStart,
    output logic             oFrameStart,
    output logic             oFrameDone,
    output logic             oBusy
);

    scanout_state_e state_q, state_d;
    logic [7:0] scx_q, scx_d;
    logic [7:0] scy_q, scy_d;
    logic [7:0] bgp_q, bgp_d;
    logic [7:0] x_q, x_d;
    logic [7:0] y_q, y_d;
    logic [4:0] fetch_q, fetch_d;
    logic       rd_pend_q, rd_pend_d;

    logic       run;
    logic       beat;
    logic       line_end;
    logic       frame_end;
    logic       issue;
    logic       slot_clear;
    logic       cur_valid;
    logic       nxt_valid;
    logic [1:0] shade;
    logic [4:0] words_line;
    logic [7:0] line_y;
    logic [4:0] word_col;

    assign run        = (state_q == SCANOUT_RUN);
    assign beat       = oValid && iReady;
    assign line_end   = beat && (x_q == 8'(LCD_W - 1));
    assign frame_end  = line_end && (y_q == 8'(LCD_H - 1));
    // A fine-scrolled line straddles one extra word.
    assign words_line = 5'(LCD_W / 8) + {4'd0, |scx_q[2:0]};
    assign issue      = run && !rd_pend_q && !nxt_valid && (fetch_q < words_line) && !line_end;
    // A response still in flight at line end belongs to the old line and is dropped here.
    assign slot_clear = line_end || !run;
    assign line_y     = scy_q + y_q;
    assign word_col   = scx_q[7:3] + fetch_q;

    gpu_fb_pixel_shifter u_shifter (
        .clk       (iClock),
        .rst_n     (iReset_n),
        .clear     (slot_clear),
        .load      (rd_pend_q),
        .data      (iFbData),
        .accept    (beat),
        .fine      (scx_q[2:0]),
        .x_lo      (x_q[2:0]),
        .bgp       (bgp_q),
        .cur_valid (cur_valid),
        .nxt_valid (nxt_valid),
        .shade     (shade)
    );

    always_comb begin
        state_d   = state_q;
        scx_d     = scx_q;
        scy_d     = scy_q;
        bgp_d     = bgp_q;
        x_d       = x_q;
        y_d       = y_q;
        fetch_d   = fetch_q;
        rd_pend_d = issue;
        case (state_q)
            SCANOUT_IDLE: begin
                if (iEnable) begin
                    scx_d   = iScx;
                    scy_d   = iScy;
                    bgp_d   = iBgp;
                    x_d     = '0;
                    y_d     = '0;
                    fetch_d = '0;
                    state_d = SCANOUT_RUN;
                end
            end
            SCANOUT_RUN: begin
                if (issue) begin
                    fetch_d = fetch_q + 5'd1;
                end
                if (beat) begin
                    x_d = x_q + 8'd1;
                end
                if (line_end) begin
                    x_d     = '0;
                    fetch_d = '0;
                    bgp_d   = iBgp;
                    if (frame_end) begin
                        state_d = SCANOUT_DONE;
                    end else begin
                        y_d = y_q + 8'd1;
                    end
                end
            end
            SCANOUT_DONE: begin
                y_d     = '0;
                state_d = SCANOUT_IDLE;
            end
            default: state_d = SCANOUT_IDLE;
        endcase
    end

    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            state_q   <= SCANOUT_IDLE;
            scx_q     <= '0;
            scy_q     <= '0;
            bgp_q     <= '0;
            x_q       <= '0;
            y_q       <= '0;
            fetch_q   <= '0;
            rd_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            scx_q     <= scx_d;
            scy_q     <= scy_d;
            bgp_q     <= bgp_d;
            x_q       <= x_d;
            y_q       <= y_d;
            fetch_q   <= fetch_d;
            rd_pend_q <= rd_pend_d;
        end
    end

    assign oFbRe       = issue;
    assign oFbAddr     = issue ? {line_y, word_col} : '0;
    assign oValid      = run && cur_valid;
    assign oPixel      = oValid ? shade : 2'd0;
    assign oLineStart  = oValid && (x_q == 8'd0);
    assign oFrameStart = oLineStart && (y_q == 8'd0);
    assign oFrameDone  = (state_q == SCANOUT_DONE);
    assign oBusy       = (state_q != SCANOUT_IDLE);

endmodule

// File: tb/tb_gpu_fbuffer_scanout.sv
// Randomized bench for gpu_fbuffer_scanout: a frame-level pixel/address model plus
// directed scroll, palette, enable-drop and mid-frame reset scenarios.
module tb_gpu_fbuffer_scanout;

    localparam int W = 160;
    localparam int H = 144;

    logic        iClock;
    logic        iReset_n;
    logic        iEnable;
    logic [7:0]  iScx;
    logic [7:0]  iScy;
    logic [7:0]  iBgp;
    logic [12:0] oFbAddr;
    logic        oFbRe;
    logic [15:0] iFbData;
    logic [1:0]  oPixel;
    logic        oValid;
    logic        iReady;
    logic        oLineStart;
    logic        oFrameStart;
    logic        oFrameDone;
    logic        oBusy;

    gpu_fbuffer_scanout dut (
        .iClock      (iClock),
        .iReset_n    (iReset_n),
        .iEnable     (iEnable),
        .iScx        (iScx),
        .iScy        (iScy),
        .iBgp        (iBgp),
        .oFbAddr     (oFbAddr),
        .oFbRe       (oFbRe),
        .iFbData     (iFbData),
        .oPixel      (oPixel),
        .oValid      (oValid),
        .iReady      (iReady),
        .oLineStart  (oLineStart),
        .oFrameStart (oFrameStart),
        .oFrameDone  (oFrameDone),
        .oBusy       (oBusy)
    );

    initial begin
        iClock = 1'b0;
        forever #5 iClock = ~iClock;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Frame configuration owned by the main sequence.
    logic [15:0] mem [0:8191];
    int   cfg_scx, cfg_scy, cfg_bgp, frame_id, tok;
    bit   ready_high;
    bit   mon_en;

    // Model state owned by the monitor.
    logic [7:0] bgp_line [0:H];
    int   ex, ey, beats, fetch_y, fetch_k, fetch_total, retired, gap, done_cnt, seen_tok, nw;
    bit   prev_re, hold_pend;
    int   hold_val;

    function automatic int ref_pixel(input int x, input int y);
        int sx, sy, p, c;
        logic [15:0] w;
        sx = (cfg_scx + x) % 256;
        sy = (cfg_scy + y) % 256;
        w  = mem[sy * 32 + sx / 8];
        p  = sx % 8;
        c  = 2 * int'(w[15 - p]) + int'(w[7 - p]);
        return (int'(bgp_line[y]) >> (2 * c)) & 3;
    endfunction

    // Monitor at negedge, LCD/RAM-side driver just after posedge.
    initial begin : mon_drv
        bit          re_now;
        logic [12:0] addr_now;
        logic [7:0]  bgp_drive;
        int          exp_addr;
        seen_tok = 0; bgp_drive = 8'h00; prev_re = 1'b0; hold_pend = 1'b0;
        ex = 0; ey = 0; beats = 0; fetch_y = 0; fetch_k = 0; fetch_total = 0;
        retired = 0; gap = 0; done_cnt = 0; nw = 20;
        iReady = 1'b0; iFbData = 16'h0; iBgp = 8'h0;
        forever begin
            @(negedge iClock);
            if (tok != seen_tok) begin
                seen_tok = tok;
                ex = 0; ey = 0; beats = 0; fetch_y = 0; fetch_k = 0; fetch_total = 0;
                retired = 0; gap = 0; done_cnt = 0; hold_pend = 1'b0;
                nw = (cfg_scx % 8 != 0) ? 21 : 20;
                bgp_drive = 8'(cfg_bgp);
                bgp_line[0] = 8'(cfg_bgp);
            end
            re_now   = oFbRe;
            addr_now = oFbAddr;
            if (mon_en) begin
                if (oFbRe) begin
                    chk("re_back_to_back", int'(prev_re), 0);
                    if (fetch_k == nw) begin
                        fetch_y++;
                        fetch_k = 0;
                    end
                    chk("fetch_line", fetch_y, ey);
                    chk("slot_room", int'((fetch_k - retired) <= 1), 1);
                    exp_addr = ((cfg_scy + fetch_y) % 256) * 32 + ((cfg_scx / 8 + fetch_k) % 32);
                    chk("fb_addr", int'(oFbAddr), exp_addr);
                    if (frame_id == 2 && fetch_y == 0 && fetch_k < 3)
                        chk("dir_col_wrap", int'(oFbAddr), 200 * 32 + ((fetch_k == 0) ? 31 : fetch_k - 1));
                    if (frame_id == 2 && fetch_y == 56 && fetch_k == 0)
                        chk("dir_row_wrap", int'(oFbAddr), 31);
                    fetch_k++;
                    fetch_total++;
                end
                if (hold_pend) begin
                    chk("hold_valid", int'(oValid), 1);
                    chk("hold_beat", int'({oPixel, oLineStart, oFrameStart}), hold_val);
                    hold_pend = 1'b0;
                end
                if (oValid && iReady) begin
                    chk("pixel", int'(oPixel), ref_pixel(ex, ey));
                    chk("line_start", int'(oLineStart), int'(ex == 0));
                    chk("frame_start", int'(oFrameStart), int'(ex == 0 && ey == 0));
                    if (ready_high && ex == 0 && ey > 0)
                        chk("line_gap", gap, 2);
                    if (frame_id == 0 && ey == 0 && ex < 8)
                        chk("dir_ff00", int'(oPixel), 2);
                    if (frame_id == 1 && ey == 0 && ex == 0)
                        chk("dir_00ff_p3", int'(oPixel), 1);
                    gap = 0;
                    if ((cfg_scx + ex) % 8 == 7) retired++;
                    if (ex == 80 && ey < H) begin
                        bgp_drive = 8'($urandom);
                        bgp_line[ey + 1] = bgp_drive;
                    end
                    beats++;
                    if (ex == W - 1) begin
                        ex = 0;
                        ey++;
                        retired = 0;
                    end else begin
                        ex++;
                    end
                end else if (oValid) begin
                    hold_pend = 1'b1;
                    hold_val  = int'({oPixel, oLineStart, oFrameStart});
                end else if (beats > 0) begin
                    gap++;
                end
                if (oFrameDone) begin
                    done_cnt++;
                    chk("done_after_last", beats, W * H);
                end
            end
            prev_re = oFbRe;
            @(posedge iClock);
            #1;
            iFbData = re_now ? mem[addr_now] : 16'($urandom);
            iReady  = ready_high ? 1'b1 : 1'($urandom % 2);
            iBgp    = bgp_drive;
        end
    end

    task automatic setup_frame(input int id, input int scx, input int scy, input int bgp, input bit rh);
        frame_id   = id;
        cfg_scx    = scx;
        cfg_scy    = scy;
        cfg_bgp    = bgp;
        ready_high = rh;
        tok++;
        mon_en     = 1'b1;
        iScx       = 8'(scx);
        iScy       = 8'(scy);
        repeat (3) @(posedge iClock);
        #1;
        iEnable = 1'b1;
        for (int i = 0; i < 10 && !oBusy; i++) @(negedge iClock);
        chk("start_busy", int'(oBusy), 1);
        iScx = 8'($urandom);
        iScy = 8'($urandom);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 70000 && done_cnt == 0; i++) @(negedge iClock);
        chk("frame_done_seen", int'(done_cnt > 0), 1);
        repeat (4) @(negedge iClock);
        chk("done_once", done_cnt, 1);
        chk("beats_total", beats, W * H);
        chk("fetch_total", fetch_total, H * nw);
        chk("idle_after_done", int'(oBusy), 0);
        chk("idle_no_valid", int'(oValid), 0);
    endtask

    initial begin : main_seq
        iReset_n = 1'b0; iEnable = 1'b0; iScx = 8'h0; iScy = 8'h0;
        mon_en = 1'b0; tok = 0; frame_id = 0; ready_high = 1'b1;
        cfg_scx = 0; cfg_scy = 0; cfg_bgp = 0;
        for (int i = 0; i < 8192; i++) mem[i] = 16'($urandom);
        repeat (3) @(posedge iClock);
        #1;
        chk("rst_re", int'(oFbRe), 0);
        chk("rst_addr", int'(oFbAddr), 0);
        chk("rst_valid", int'(oValid), 0);
        chk("rst_pixel", int'(oPixel), 0);
        chk("rst_busy", int'(oBusy), 0);
        chk("rst_done", int'(oFrameDone), 0);
        #2 iReset_n = 1'b1;

        // Unscrolled frame, reset asserted mid-line at (80,10).
        mem[0] = 16'hFF00;
        setup_frame(0, 0, 0, 8'hE4, 1'b1);
        iEnable = 1'b0;
        for (int i = 0; i < 5000 && !(ey == 10 && ex >= 80); i++) @(posedge iClock);
        chk("reach_x80_y10", int'(ey == 10 && ex >= 80), 1);
        #3;
        mon_en   = 1'b0;
        iReset_n = 1'b0;
        #1;
        chk("arst_valid", int'(oValid), 0);
        chk("arst_re", int'(oFbRe), 0);
        chk("arst_busy", int'(oBusy), 0);
        chk("arst_flags", int'({oPixel, oLineStart, oFrameStart, oFrameDone}), 0);
        repeat (3) @(negedge iClock);
        chk("arst_hold_busy", int'(oBusy), 0);
        #2 iReset_n = 1'b1;

        // Fine scroll 3, random ready, enable dropped at line 70.
        mem[0] = 16'h00FF;
        setup_frame(1, 3, 0, 8'hE4, 1'b0);
        for (int i = 0; i < 40000 && ey < 70; i++) @(negedge iClock);
        chk("reach_y70", int'(ey >= 70), 1);
        iEnable = 1'b0;
        wait_done();
        repeat (10) @(negedge iClock);
        chk("stays_idle", int'(oBusy), 0);

        // Column and row wrap-around, full rate.
        setup_frame(2, 250, 200, int'($urandom % 256), 1'b1);
        iEnable = 1'b0;
        wait_done();

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
